pwm_dtchan: RTL and testbench

Parametrised PWM channel that generalises the team's 8-bit PWM channel. It provides:
- configurable counter width;
- a double-buffered duty register that updates only at period wrap;
- cycle-by-cycle latched current limiting;
- selectable inversion and enable;
- a programmable dead-time generator that produces complementary high-side/low-side gate drives.

One instance drives one half-bridge leg of the brushed-DC motor driver.

---
 rtl/pwm_pkg.sv | 22 ++
 rtl/pwm_deadband.sv | 101 ++++++++++
 rtl/pwm_dtchan.sv | 120 ++++++++++++
 tb/tb_pwm_dtchan.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types and default constants for the pwm_dtchan channel
//
// Contents:
//   dt_state_e     dead-time generator state (off / dead band / driving)
//   PWM_WIDTH      default counter and duty width
//   PWM_DT_WIDTH   default dead-time counter width
//   PWM_MIN_CLIP   default minimum effective duty (keeps bootstrap caps charged)
//   PWM_MAX_CLIP   default maximum effective duty
package pwm_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_DEAD  = 2'd1,
    ST_DRIVE = 2'd2
  } dt_state_e;

  localparam int PWM_WIDTH    = 8;
  localparam int PWM_DT_WIDTH = 4;
  localparam int PWM_MIN_CLIP = 3;
  localparam int PWM_MAX_CLIP = 251;

endpackage : pwm_pkg

// File: rtl/pwm_deadband.sv
// rtl/pwm_deadband.sv - dead-time generator producing complementary gate drives
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   c          polarity-corrected modulator level
//   enablepwm  0 forces both gates low (state OFF)
//   dtval      dead time in clk cycles, sampled on every entry to DEAD
//   pwmout     registered gate drives: [0] high side, [1] low side
module pwm_deadband
  import pwm_pkg::*;
#(
  parameter int DT_WIDTH = PWM_DT_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                c,
  input  logic                enablepwm,
  input  logic [DT_WIDTH-1:0] dtval,
  output logic [1:0]          pwmout
);

  localparam logic [DT_WIDTH-1:0] DT_ONE = DT_WIDTH'(1);

  dt_state_e           state, state_d;
  logic                lvl, lvl_d;
  logic [DT_WIDTH-1:0] dt_cnt, dt_cnt_d;
  logic [1:0]          pwmout_d;

  // State register; pwmout is registered alongside so it changes on the same
  // edge as the state it reflects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_OFF;
      lvl    <= 1'b0;
      dt_cnt <= '0;
      pwmout <= 2'b00;
    end else begin
      state  <= state_d;
      lvl    <= lvl_d;
      dt_cnt <= dt_cnt_d;
      pwmout <= pwmout_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d  = state;
    lvl_d    = lvl;
    dt_cnt_d = dt_cnt;
    if (!enablepwm) begin
      state_d = ST_OFF;
    end else begin
      unique case (state)
        ST_OFF: begin
          state_d  = ST_DEAD;
          lvl_d    = c;
          dt_cnt_d = dtval;
        end
        ST_DEAD: begin
          if (c != lvl) begin
            // Level moved during the dead band: restart the window. With a
            // zero dead time there is no window to wait for.
            lvl_d    = c;
            dt_cnt_d = dtval;
            if (dtval == '0) begin
              state_d = ST_DRIVE;
            end
          end else if (dt_cnt <= DT_ONE) begin
            // A count of 1 means this edge completes the final dead cycle;
            // 0 only occurs when the window was loaded with no dead time.
            state_d = ST_DRIVE;
          end else begin
            dt_cnt_d = dt_cnt - DT_ONE;
          end
        end
        ST_DRIVE: begin
          if (c != lvl) begin
            lvl_d = c;
            if (dtval != '0) begin
              state_d  = ST_DEAD;
              dt_cnt_d = dtval;
            end
          end
        end
        default: begin
          state_d = ST_OFF;
        end
      endcase
    end
  end

  // Output logic: only DRIVE ever asserts a gate, and then exactly one.
  always_comb begin
    pwmout_d = 2'b00;
    if (state_d == ST_DRIVE) begin
      pwmout_d = {~lvl_d, lvl_d};
    end
  end

endmodule : pwm_deadband

// File: rtl/pwm_dtchan.sv
// rtl/pwm_dtchan.sv - PWM channel with buffered duty, current limit and dead time
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   pwmcntce      counter tick enable
//   pwmldce       strobe loading wrtdata into the pending duty register
//   wrtdata       duty value
//   dtval         dead time in clk cycles (0 = none)
//   invertpwm     inverts the modulator level ahead of the dead-time stage
//   enablepwm     0 forces both gates low
//   currentlimit  overcurrent; ends on-time for the rest of the period
//   pwmout        [0] high-side gate, [1] low-side gate
//   period_start  one-clk pulse following each counter wrap tick
//   climit_flag   current-limit trip latched for this period
module pwm_dtchan
  import pwm_pkg::*;
#(
  parameter int WIDTH    = PWM_WIDTH,
  parameter int DT_WIDTH = PWM_DT_WIDTH,
  parameter int MIN_CLIP = PWM_MIN_CLIP,
  parameter int MAX_CLIP = PWM_MAX_CLIP
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pwmcntce,
  input  logic                pwmldce,
  input  logic [WIDTH-1:0]    wrtdata,
  input  logic [DT_WIDTH-1:0] dtval,
  input  logic                invertpwm,
  input  logic                enablepwm,
  input  logic                currentlimit,
  output logic [1:0]          pwmout,
  output logic                period_start,
  output logic                climit_flag
);

  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] DUTY_RST = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] CLIP_LO  = WIDTH'(MIN_CLIP);
  localparam logic [WIDTH-1:0] CLIP_HI  = WIDTH'(MAX_CLIP);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] active;
  logic [WIDTH-1:0] eff_duty;
  logic             wrap;
  logic             se;
  logic             climit;
  logic             c;

  assign wrap = pwmcntce && (cnt == CNT_MAX);

  // Counter and double-buffered duty. A load on the wrap tick lands in
  // pending while active takes the previous pending value, so that write
  // applies one period later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      pending      <= DUTY_RST;
      active       <= DUTY_RST;
      period_start <= 1'b0;
    end else begin
      if (pwmcntce) begin
        cnt <= cnt + WIDTH'(1);
      end
      if (pwmldce) begin
        pending <= wrtdata;
      end
      if (wrap) begin
        active <= pending;
      end
      period_start <= wrap;
    end
  end

  always_comb begin
    eff_duty = active;
    if (active < CLIP_LO) begin
      eff_duty = CLIP_LO;
    end else if (active > CLIP_HI) begin
      eff_duty = CLIP_HI;
    end
  end

  // Modulator and current-limit latch. currentlimit acts on every clk, not
  // just on ticks. se is only ever set on the wrap tick, which is also where
  // climit releases, so a trip blocks on-time until the next period begins.
  // CLIP_HI stays below CNT_MAX, so the wrap tick never coincides with the
  // duty-match tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      se     <= 1'b0;
      climit <= 1'b0;
    end else if (currentlimit) begin
      se     <= 1'b0;
      climit <= 1'b1;
    end else if (wrap) begin
      se     <= 1'b1;
      climit <= 1'b0;
    end else if (pwmcntce && (cnt == eff_duty)) begin
      se <= 1'b0;
    end
  end

  assign c           = se ^ invertpwm;
  assign climit_flag = climit;

  pwm_deadband #(
    .DT_WIDTH (DT_WIDTH)
  ) u_deadband (
    .clk       (clk),
    .rst_n     (rst_n),
    .c         (c),
    .enablepwm (enablepwm),
    .dtval     (dtval),
    .pwmout    (pwmout)
  );

endmodule : pwm_dtchan

// File: tb/tb_pwm_dtchan.sv
// tb/tb_pwm_dtchan.sv - self-checking bench for pwm_dtchan
module tb_pwm_dtchan;

  localparam int N    = 256;
  localparam int MINC = 3;
  localparam int MAXC = 251;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pwmcntce = 1'b1;
  logic       pwmldce = 1'b0;
  logic [7:0] wrtdata = 8'h80;
  logic [9:0] wrtdata10 = 10'h200;
  logic [3:0] dtval = 4'd0;
  logic       invertpwm = 1'b0;
  logic       enablepwm = 1'b1;
  logic       currentlimit = 1'b0;
  logic [1:0] pwmout, pwmout10;
  logic       period_start, ps10, climit_flag, cf10;

  always #5 clk = ~clk;

  pwm_dtchan dut (
    .clk(clk), .rst_n(rst_n), .pwmcntce(pwmcntce), .pwmldce(pwmldce),
    .wrtdata(wrtdata), .dtval(dtval), .invertpwm(invertpwm),
    .enablepwm(enablepwm), .currentlimit(currentlimit), .pwmout(pwmout),
    .period_start(period_start), .climit_flag(climit_flag)
  );

  pwm_dtchan #(.WIDTH(10), .DT_WIDTH(4), .MIN_CLIP(3), .MAX_CLIP(1000)) dut10 (
    .clk(clk), .rst_n(rst_n), .pwmcntce(pwmcntce), .pwmldce(pwmldce),
    .wrtdata(wrtdata10), .dtval(dtval), .invertpwm(invertpwm),
    .enablepwm(enablepwm), .currentlimit(currentlimit), .pwmout(pwmout10),
    .period_start(ps10), .climit_flag(cf10)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: period position, duty buffers, trip latch, and a history
  // of (enable, level) samples from which the gate state is derived.
  int m_cnt, m_pend, m_act;
  bit m_trip, m_started, m_se, m_ps;
  bit en_h[0:31];
  bit c_h[0:31];

  typedef struct {
    logic [7:0] duty;
    int         on_ticks;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int eff(input int a);
    if (a < MINC) return MINC;
    if (a > MAXC) return MAXC;
    return a;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_pend = 128; m_act = 128;
    m_trip = 0; m_started = 0; m_se = 0; m_ps = 0;
    for (int i = 0; i < 32; i++) begin
      en_h[i] = 0;
      c_h[i]  = 0;
    end
  endtask

  task automatic model_edge();
    bit wrap;
    wrap = pwmcntce && (m_cnt == N - 1);
    for (int i = 31; i > 0; i--) begin
      en_h[i] = en_h[i-1];
      c_h[i]  = c_h[i-1];
    end
    en_h[0] = enablepwm;
    c_h[0]  = m_se ^ invertpwm;
    if (pwmcntce) m_cnt = (m_cnt + 1) % N;
    if (wrap) m_act = m_pend;
    if (pwmldce) m_pend = int'(wrtdata);
    if (currentlimit) m_trip = 1;
    else if (wrap) m_trip = 0;
    if (wrap) m_started = 1;
    m_ps = wrap;
    // On for counts 0..duty of a period that began with a wrap, unless tripped.
    m_se = m_started && !m_trip && (m_cnt <= eff(m_act));
  endtask

  // Gates drive the latest level only once enable has held for the dead band
  // (at least one settling edge) and the level has been steady across it.
  function automatic logic [1:0] exp_pwm();
    int d;
    int w;
    bit ok;
    d  = int'(dtval);
    w  = (d == 0) ? 1 : d;
    ok = 1;
    for (int i = 0; i <= w; i++) if (!en_h[i]) ok = 0;
    for (int i = 0; i <= d; i++) if (c_h[i] != c_h[0]) ok = 0;
    return ok ? {~c_h[0], c_h[0]} : 2'b00;
  endfunction

  function automatic logic [1:0] drive_of(input bit lvl);
    return {~lvl, lvl};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("pwmout", int'(pwmout), int'(exp_pwm()));
    check("period_start", int'(period_start), int'(m_ps));
    check("climit_flag", int'(climit_flag), int'(m_trip));
    check("no_overlap", int'(pwmout == 2'b11), 0);
  endtask

  task automatic wait_ps(input string name);
    int k;
    k = 0;
    while (!period_start && k < N + 8) begin
      step();
      k++;
    end
    check(name, int'(period_start), 1);
  endtask

  task automatic measure(output int hi0, output int hi1, output int nps, output int first);
    hi0 = 0; hi1 = 0; nps = 0; first = 0;
    for (int i = 0; i < N; i++) begin
      step();
      if (i == 0) first = int'(pwmout[0]);
      hi0 += int'(pwmout[0]);
      hi1 += int'(pwmout[1]);
      nps += int'(period_start);
    end
  endtask

  task automatic count_zero(output int z);
    z = 0;
    do begin
      step();
      if (pwmout == 2'b00) z++;
    end while (pwmout == 2'b00 && z < 30);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int hi0, hi1, nps, first, k, z, bad;

    vecs[0] = '{8'h80, 129};
    vecs[1] = '{8'h01, 4};
    vecs[2] = '{8'hFF, 252};
    vecs[3] = '{8'h00, 4};
    vecs[4] = '{8'h03, 4};
    vecs[5] = '{8'hFB, 252};
    vecs[6] = '{8'hFA, 251};
    vecs[7] = '{8'h04, 5};

    // Reset values
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_pwmout", int'(pwmout), 0);
    check("rst_period_start", int'(period_start), 0);
    check("rst_climit_flag", int'(climit_flag), 0);
    check("rst_pwmout10", int'(pwmout10), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Wide instance: duty 1023 clips to 1000 -> 1001 ticks per 1024
    wrtdata10 = 10'h3FF;
    pwmldce = 1'b1;
    step();
    pwmldce = 1'b0;
    k = 0;
    while (!ps10 && k < 1100) begin
      step();
      k++;
    end
    check("w10_wrap", int'(ps10), 1);
    hi0 = 0; bad = 0;
    for (int i = 0; i < 1024; i++) begin
      step();
      hi0 += int'(pwmout10[0]);
      bad += int'(pwmout10 == 2'b11);
    end
    check("w10_on_ticks", hi0, 1001);
    check("w10_overlap", bad, 0);

    // Table of duty writes and their on-times per period
    foreach (vecs[v]) begin
      if (m_cnt == N - 1) step();
      wrtdata = vecs[v].duty;
      pwmldce = 1'b1;
      step();
      pwmldce = 1'b0;
      wait_ps("vec_wrap");
      check("vec_pre_low", int'(pwmout[0]), 0);
      measure(hi0, hi1, nps, first);
      check("vec_on_hs", hi0, vecs[v].on_ticks);
      check("vec_on_ls", hi1, N - vecs[v].on_ticks);
      check("vec_ps_count", nps, 1);
      check("vec_first_high", first, 1);
    end

    // Write coinciding with the wrap tick applies one period later
    wrtdata = 8'h10;
    pwmldce = 1'b1;
    step();
    pwmldce = 1'b0;
    k = 0;
    while (m_cnt != N - 1 && k < N + 8) begin
      step();
      k++;
    end
    wrtdata = 8'h40;
    pwmldce = 1'b1;
    step();
    pwmldce = 1'b0;
    check("wrapwr_ps", int'(period_start), 1);
    measure(hi0, hi1, nps, first);
    check("wrapwr_old", hi0, 17);
    measure(hi0, hi1, nps, first);
    check("wrapwr_new", hi0, 65);

    // One-clk current limit at count 40
    wrtdata = 8'h80;
    pwmldce = 1'b1;
    step();
    pwmldce = 1'b0;
    wait_ps("cl_wrap");
    k = 0;
    while (m_cnt != 40 && k < N + 8) begin
      step();
      k++;
    end
    check("cl_pre_high", int'(pwmout[0]), 1);
    currentlimit = 1'b1;
    step();
    currentlimit = 1'b0;
    check("cl_flag_set", int'(climit_flag), 1);
    step();
    check("cl_drop", int'(pwmout[0]), 0);
    bad = 0; k = 0;
    while (!period_start && k < N) begin
      step();
      k++;
      if (!period_start) begin
        if (pwmout[0]) bad++;
        if (!climit_flag) bad++;
      end
    end
    check("cl_hold", bad, 0);
    check("cl_wrap_seen", int'(period_start), 1);
    check("cl_flag_clear", int'(climit_flag), 0);
    step();
    check("cl_resume", int'(pwmout[0]), 1);

    // Dead time of 5 with a frozen counter so only invertpwm moves the level
    pwmcntce = 1'b0;
    enablepwm = 1'b0;
    dtval = 4'd5;
    step();
    enablepwm = 1'b1;
    repeat (8) step();
    check("db_settled", int'(pwmout), int'(drive_of(m_se ^ invertpwm)));
    invertpwm = ~invertpwm;
    count_zero(z);
    check("db_window", z, 5);
    check("db_new_state", int'(pwmout), int'(drive_of(m_se ^ invertpwm)));
    invertpwm = ~invertpwm;
    repeat (3) step();
    check("db_mid_dead", int'(pwmout), 0);
    invertpwm = ~invertpwm;
    count_zero(z);
    check("db_restart", z, 5);
    check("db_restart_state", int'(pwmout), int'(drive_of(m_se ^ invertpwm)));

    // Enable drop mid on-time, then re-enable with dead time 3
    pwmcntce = 1'b1;
    invertpwm = 1'b0;
    wait_ps("en_wrap");
    repeat (10) step();
    check("en_pre", int'(pwmout), 1);
    enablepwm = 1'b0;
    dtval = 4'd3;
    step();
    check("en_off", int'(pwmout), 0);
    repeat (2) step();
    enablepwm = 1'b1;
    count_zero(z);
    check("en_dead", z, 3);
    check("en_drive", int'(pwmout), 1);

    // Randomized traffic against the model
    for (int b = 0; b < 16; b++) begin
      enablepwm = 1'b0;
      dtval = 4'($urandom_range(0, 6));
      step();
      for (int i = 0; i < 250; i++) begin
        pwmcntce = ($urandom_range(0, 7) != 0);
        currentlimit = ($urandom_range(0, 39) == 0);
        pwmldce = ($urandom_range(0, 29) == 0);
        wrtdata = 8'($urandom);
        if ($urandom_range(0, 59) == 0) invertpwm = ~invertpwm;
        enablepwm = ($urandom_range(0, 99) != 0);
        step();
      end
    end

    // Reset mid-period while a trip is latched
    pwmcntce = 1'b1; pwmldce = 1'b0; enablepwm = 1'b1; invertpwm = 1'b0;
    dtval = 4'd0;
    repeat (50) step();
    currentlimit = 1'b1;
    step();
    currentlimit = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_pwmout", int'(pwmout), 0);
    check("mid_rst_ps", int'(period_start), 0);
    check("mid_rst_flag", int'(climit_flag), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (300) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pwm_dtchan
